// File: rtl/sender_wrapper.sv
// sender_wrapper: buffered UART transmitter; FIFO feeding an 8N1 serializer (8E1 when SENDER_PARITY_EN is defined).
// Latency: a byte written on edge n into an empty FIFO with the serializer idle drives the start bit from edge n+1.
// Backpressure: none toward the writer; writes while full are dropped and latched into sticky overflow.
module sender_wrapper #(
    parameter int SENDER_PERIOD = 1292,
    parameter int DEPTH_LOG     = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in,
    input  logic                 valid,
    output logic                 full,
    output logic [DEPTH_LOG:0]   count,
    output logic                 busy,
    output logic                 overflow,
    output logic                 out
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG+1)'(DEPTH);
    localparam int TW = $clog2(SENDER_PERIOD);
    localparam logic [TW-1:0] T_LAST = TW'(SENDER_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef SENDER_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    // ---------------- FIFO ----------------
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG-1:0]  wr_ptr;
    logic [DEPTH_LOG-1:0]  rd_ptr;
    logic [DEPTH_LOG:0]    count_nxt;
    logic [7:0]            head;
    logic                  push;
    logic                  pop;

    // full is the registered flag from the previous edge, so a write on a pop edge while full is still dropped
    assign push = valid && !full;
    assign head = mem[rd_ptr];

    // occupancy bookkeeping: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + (DEPTH_LOG+1)'(1);
        end else if (!push && pop) begin
            count_nxt = count - (DEPTH_LOG+1)'(1);
        end
    end

    // storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in;
        end
    end

    // pointers, count, full and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_COUNT);
            if (valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------- serializer ----------------
    state_t           state;
    state_t           state_nxt;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_nxt;
    logic [7:0]       shift;
    logic [7:0]       shift_nxt;
    logic             out_nxt;
    logic             busy_nxt;
    logic             bit_end;
`ifdef SENDER_PARITY_EN
    logic             parity_bit;
    logic             parity_nxt;
`endif

    assign bit_end = (timer == T_LAST);

    // next-state and next-output logic; every bit lasts SENDER_PERIOD cycles
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer + 1'b1;
        bit_nxt    = bit_idx;
        shift_nxt  = shift;
        out_nxt    = out;
        busy_nxt   = busy;
        pop        = 1'b0;
`ifdef SENDER_PARITY_EN
        parity_nxt = parity_bit;
`endif
        case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                out_nxt   = 1'b1;
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_nxt  = head;
`ifdef SENDER_PARITY_EN
                    parity_nxt = ^head;
`endif
                    state_nxt  = ST_START;
                    out_nxt    = 1'b0;
                    busy_nxt   = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    state_nxt = ST_DATA;
                    out_nxt   = shift[0];
                    shift_nxt = shift >> 1;
                    bit_nxt   = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    if (bit_idx == 3'd7) begin
`ifdef SENDER_PARITY_EN
                        state_nxt = ST_PARITY;
                        out_nxt   = parity_bit;
`else
                        state_nxt = ST_STOP;
                        out_nxt   = 1'b1;
`endif
                    end else begin
                        bit_nxt   = bit_idx + 3'd1;
                        out_nxt   = shift[0];
                        shift_nxt = shift >> 1;
                    end
                end
            end
`ifdef SENDER_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    state_nxt = ST_STOP;
                    out_nxt   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    if (count != '0) begin
                        // back-to-back: the next start bit follows the stop bit with no idle gap
                        pop        = 1'b1;
                        shift_nxt  = head;
`ifdef SENDER_PARITY_EN
                        parity_nxt = ^head;
`endif
                        state_nxt  = ST_START;
                        out_nxt    = 1'b0;
                    end else begin
                        state_nxt  = ST_IDLE;
                        out_nxt    = 1'b1;
                        busy_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = '0;
                out_nxt   = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // serializer state register; reset aborts any frame and returns the line high
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'd0;
            out        <= 1'b1;
            busy       <= 1'b0;
`ifdef SENDER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            bit_idx    <= bit_nxt;
            shift      <= shift_nxt;
            out        <= out_nxt;
            busy       <= busy_nxt;
`ifdef SENDER_PARITY_EN
            parity_bit <= parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sender_wrapper.sv
// tb_sender_wrapper: directed stimulus with a queued scoreboard checked by a serial-line receiver monitor.
// Latency: receiver samples each bit at its midpoint (half a bit period after the bit starts).
// Backpressure: none; overflow and drop behaviour are exercised directly.
`timescale 1ns/1ps
module tb_sender_wrapper;

    localparam int P  = 4;
    localparam int DL = 2;
`ifdef SENDER_PARITY_EN
    localparam int FB   = 11;
    localparam int EXPF = 11;
`else
    localparam int FB   = 10;
    localparam int EXPF = 9;
`endif
    localparam int FL = FB * P;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [7:0]  din;
    logic        full;
    logic [DL:0] count;
    logic        busy;
    logic        overflow;
    logic        dout;

    int checks    = 0;
    int errors    = 0;
    int frames_rx = 0;
    int rst_cnt   = 0;
    bit mon_en    = 1'b0;
    logic [7:0] sb [$];

    sender_wrapper #(.SENDER_PERIOD(P), .DEPTH_LOG(DL)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (din),
        .valid    (valid),
        .full     (full),
        .count    (count),
        .busy     (busy),
        .overflow (overflow),
        .out      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // counts reset edges so the monitor can discard frames cut short by reset
    always @(posedge clk) if (reset) rst_cnt <= rst_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // expected line level for bit slot idx of a frame carrying b
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef SENDER_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_drain();
        int n;
        n = 0;
        while ((busy || count != '0 || sb.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 2000), 32'd1);
        repeat (4) tick();
    endtask

    // single frame from idle, checked cycle by cycle against the expected waveform
    task automatic send_one(input logic [7:0] b);
        int bad;
        bad = 0;
        din = b;
        valid = 1'b1;
        sb.push_back(b);
        tick();
        valid = 1'b0;
        chk("wr_count", 32'(count), 32'd1);
        chk("wr_out_still_idle", 32'(dout), 32'd1);
        for (int k = 1; k <= FL; k++) begin
            tick();
            if (k == 1) chk("pop_count", 32'(count), 32'd0);
            if (dout !== frame_bit(b, (k-1) / P)) bad++;
            if (k == FL) chk("busy_last_cycle", 32'(busy), 32'd1);
        end
        chk("frame_wave_bad_cycles", 32'(bad), 32'd0);
        tick();
        chk("busy_after_frame", 32'(busy), 32'd0);
        chk("out_after_frame", 32'(dout), 32'd1);
    endtask

    // receiver monitor: decodes frames off the line and checks them against the scoreboard
    initial begin : monitor
        logic prev;
        logic cur;
        logic stb;
        logic stp;
        logic [7:0] d;
        logic [7:0] e;
        int r0;
`ifdef SENDER_PARITY_EN
        logic par;
`endif
        prev = 1'b1;
        wait (mon_en);
        forever begin
            @(negedge clk);
            cur = dout;
            if (prev === 1'b1 && cur === 1'b0) begin
                r0 = rst_cnt;
                repeat (P/2) @(negedge clk);
                stb = dout;
                for (int b = 0; b < 8; b++) begin
                    repeat (P) @(negedge clk);
                    d[b] = dout;
                end
`ifdef SENDER_PARITY_EN
                repeat (P) @(negedge clk);
                par = dout;
`endif
                repeat (P) @(negedge clk);
                stp = dout;
                if (rst_cnt == r0) begin
                    chk("rx_frame_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("rx_start_bit", 32'(stb), 32'd0);
                        chk("rx_byte", 32'(d), 32'(e));
`ifdef SENDER_PARITY_EN
                        chk("rx_parity", 32'(par), 32'(^e));
`endif
                        chk("rx_stop_bit", 32'(stp), 32'd1);
                    end
                    frames_rx++;
                end
                cur = 1'b1;
            end
            prev = cur;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int bad;
        reset = 1'b1;
        valid = 1'b0;
        din   = 8'h00;
        repeat (3) tick();
        chk("rst_out", 32'(dout), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // 1: idle for 20 cycles
        bad = 0;
        repeat (20) begin
            tick();
            if (dout !== 1'b1 || busy !== 1'b0 || count !== '0) bad++;
        end
        chk("idle20_bad_cycles", 32'(bad), 32'd0);

        // 2: single 0xA5 frame, exact waveform and length
        send_one(8'hA5);
        wait_drain();

        // 3: three back-to-back frames with no idle gap
        bad = 0;
        for (int k = 0; k <= 3*FL + 1; k++) begin
            if (k < 3) begin
                din   = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'h55;
                valid = 1'b1;
                sb.push_back(din);
            end
            tick();
            valid = 1'b0;
            if (k >= 1 && k <= 3*FL && busy !== 1'b1) bad++;
            if (k == 2)        chk("t3_count_k2", 32'(count), 32'd2);
            if (k == FL)       chk("t3_stop1", 32'(dout), 32'd1);
            if (k == FL + 1)   chk("t3_start2_nogap", 32'(dout), 32'd0);
            if (k == FL + 1)   chk("t3_count_pop2", 32'(count), 32'd1);
            if (k == 2*FL + 1) chk("t3_start3_nogap", 32'(dout), 32'd0);
            if (k == 2*FL + 1) chk("t3_count_pop3", 32'(count), 32'd0);
            if (k == 3*FL + 1) chk("t3_busy_end", 32'(busy), 32'd0);
        end
        chk("t3_busy_gap_cycles", 32'(bad), 32'd0);
        wait_drain();
        chk("t3_frames", 32'(frames_rx), 32'd4);

        // 4: six writes into a depth-4 FIFO; the sixth is dropped
        for (int k = 0; k <= 5; k++) begin
            din   = 8'(8'h11 * (k + 1));
            valid = 1'b1;
            if (k < 5) sb.push_back(din);
            tick();
            valid = 1'b0;
            if (k == 4) begin
                chk("t4_full_k4", 32'(full), 32'd1);
                chk("t4_ovf_k4", 32'(overflow), 32'd0);
            end
            if (k == 5) begin
                chk("t4_full_k5", 32'(full), 32'd1);
                chk("t4_count_k5", 32'(count), 32'd4);
                chk("t4_ovf_k5", 32'(overflow), 32'd1);
            end
        end
        wait_drain();
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        chk("t4_full_cleared", 32'(full), 32'd0);

        // 5: reset mid-data with two bytes queued
        for (int k = 0; k <= 2; k++) begin
            din   = 8'(8'h31 + k);
            valid = 1'b1;
            tick();
            valid = 1'b0;
        end
        repeat (18) tick();
        chk("t5_count_before", 32'(count), 32'd2);
        chk("t5_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_out", 32'(dout), 32'd1);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        chk("t5_full", 32'(full), 32'd0);
        bad = 0;
        repeat (100) begin
            tick();
            if (dout !== 1'b1 || busy !== 1'b0 || count !== '0) bad++;
        end
        chk("t5_quiet_cycles", 32'(bad), 32'd0);

`ifdef SENDER_PARITY_EN
        // 6: even parity bit and 11-bit frame length
        send_one(8'h07);
        wait_drain();
        send_one(8'h03);
        wait_drain();
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("frames_total", 32'(frames_rx), 32'(EXPF));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
